// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds a 4-digit frame from a multiplexed active-low 7-segment bus.
// Define SCAN_ORDER_CHECK_EN to require captures in digit order 0,1,2,3.
module seg_scan_capture #(
   parameter int SETTLE    = 4,
   parameter int TIMEOUT_W = 21
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
   output logic [27:0] frame_seg,
   output logic [15:0] frame_hex,
   output logic [3:0]  hex_ok,
   output logic        frame_valid,
   output logic        err_timeout,
   output logic        order_err
);
   localparam logic [7:0] SETTLE_C = 8'(SETTLE);
   typedef enum logic [1:0] {IDLE, SETTLING, HELD} state_t;
   state_t               r_state, w_state_nxt;
   logic [6:0]           r_seg_m, r_seg_s;
   logic [3:0]           r_an_m, r_an_s;
   logic [10:0]          r_prev;
   logic [7:0]           r_cnt, w_cnt_nxt;
   logic [6:0]           r_slot [4];
   logic [3:0]           r_seen, w_seen_nxt, w_bit;
   logic [TIMEOUT_W-1:0] r_to;
   logic                 w_valid, w_same, w_cap, w_complete, w_tmo, w_bad;
   logic [1:0]           w_idx;

   function automatic logic [4:0] dec(input logic [6:0] s);
      case (s)
         7'b1000000: dec = 5'h10;
         7'b1111001: dec = 5'h11;
         7'b0100100: dec = 5'h12;
         7'b0110000: dec = 5'h13;
         7'b0011001: dec = 5'h14;
         7'b0010010: dec = 5'h15;
         7'b0000010: dec = 5'h16;
         7'b1111000: dec = 5'h17;
         7'b0000000: dec = 5'h18;
         7'b0010000: dec = 5'h19;
         7'b0001000: dec = 5'h1A;
         7'b0000011: dec = 5'h1B;
         7'b1000110: dec = 5'h1C;
         7'b0100001: dec = 5'h1D;
         7'b0000110: dec = 5'h1E;
         7'b0001110: dec = 5'h1F;
         default:    dec = 5'h00;
      endcase
   endfunction

   assign w_valid    = (r_an_s == 4'b1110) || (r_an_s == 4'b1101) ||
                       (r_an_s == 4'b1011) || (r_an_s == 4'b0111);
   assign w_idx      = !r_an_s[0] ? 2'd0 : !r_an_s[1] ? 2'd1 : !r_an_s[2] ? 2'd2 : 2'd3;
   assign w_same     = {r_an_s, r_seg_s} == r_prev;
   assign w_complete = &r_seen;
   assign w_tmo      = (&r_to) && !w_complete;
   assign w_bit      = 4'b0001 << w_idx;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_seg_m <= '1;
         r_seg_s <= '1;
         r_an_m  <= '1;
         r_an_s  <= '1;
         r_prev  <= '1;
      end else begin
         r_seg_m <= seg_in;
         r_seg_s <= r_seg_m;
         r_an_m  <= an_in;
         r_an_s  <= r_an_m;
         r_prev  <= {r_an_s, r_seg_s};
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end

   // Any sample change restarts the stability count; HELD blocks re-capture of an unchanged slot.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (!w_valid) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else if (!(r_state == HELD && w_same)) begin
         w_cnt_nxt   = (r_state == SETTLING && w_same) ? r_cnt + 8'd1 : 8'd1;
         w_state_nxt = (w_cnt_nxt == SETTLE_C) ? HELD : SETTLING;
      end
   end

   always_comb
      w_cap = (w_state_nxt == HELD) && !(r_state == HELD && w_same);

`ifdef SCAN_ORDER_CHECK_EN
   logic [1:0] r_exp, w_exp_eff;
   assign w_exp_eff = w_tmo ? 2'd0 : r_exp;
   assign w_bad     = w_cap && (w_idx != w_exp_eff);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_exp     <= '0;
         order_err <= 1'b0;
      end else begin
         order_err <= w_bad;
         if (w_cap) r_exp <= w_bad ? {1'b0, w_idx == 2'd0} : w_exp_eff + 2'd1;
         else if (w_tmo) r_exp <= 2'd0;
      end
`else
   assign w_bad     = 1'b0;
   assign order_err = 1'b0;
`endif

   // A rejected out-of-order digit 0 still counts as the first capture of a new frame.
   always_comb begin
      w_seen_nxt = (w_complete || w_tmo || w_bad) ? 4'h0 : r_seen;
      if (w_cap && !(w_bad && w_idx != 2'd0)) w_seen_nxt = w_seen_nxt | w_bit;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         frame_seg   <= '1;
         frame_hex   <= '0;
         hex_ok      <= '0;
         frame_valid <= 1'b0;
         err_timeout <= 1'b0;
         r_to        <= '0;
         r_seen      <= '0;
         for (int k = 0; k < 4; k++) r_slot[k] <= '1;
      end else begin
         frame_valid <= w_complete;
         err_timeout <= w_tmo;
         r_to        <= w_complete ? '0 : r_to + TIMEOUT_W'(1);
         r_seen      <= w_seen_nxt;
         if (w_cap) r_slot[w_idx] <= r_seg_s;
         if (w_complete)
            for (int k = 0; k < 4; k++) begin
               frame_seg[7*k +: 7] <= r_slot[k];
               {hex_ok[k], frame_hex[4*k +: 4]} <= dec(r_slot[k]);
            end
      end
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: table scans, corner sequences and random bus traffic checked against a reference model.
module tb_seg_scan_capture;
   localparam int SETTLE = 4;
   localparam int TW     = 6;

   logic        clk, rst;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic [27:0] frame_seg;
   logic [15:0] frame_hex;
   logic [3:0]  hex_ok;
   logic        frame_valid, err_timeout, order_err;

   seg_scan_capture #(.SETTLE(SETTLE), .TIMEOUT_W(TW)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
      .frame_seg(frame_seg), .frame_hex(frame_hex), .hex_ok(hex_ok),
      .frame_valid(frame_valid), .err_timeout(err_timeout), .order_err(order_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [27:0] segs;
      logic [15:0] hex;
      logic [3:0]  ok;
   } vec_t;

   logic [6:0]  glyph [16];
   int          n_vec, n_bad, fv_cnt, to_cnt, oe_cnt;

   // reference model state: raw sample history plus frame bookkeeping
   logic [10:0] m_m, m_s, m_p;
   int          m_run, m_to, m_exp;
   logic [3:0]  m_seen;
   logic [6:0]  m_slot [4];
   logic [27:0] e_seg;
   logic [15:0] e_hex;
   logic [3:0]  e_ok;
   logic        e_fv, e_to, e_oe;

   function automatic logic [4:0] ref_dec(input logic [6:0] s);
      ref_dec = 5'd0;
      for (int k = 0; k < 16; k++) if (glyph[k] == s) ref_dec = {1'b1, 4'(k)};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
      end
   endtask

   task automatic model_reset();
      m_m = '1; m_s = '1; m_p = '1;
      m_run = 0; m_to = 0; m_exp = 0; m_seen = '0;
      for (int k = 0; k < 4; k++) m_slot[k] = '1;
      e_seg = '1; e_hex = '0; e_ok = '0;
      e_fv = 0; e_to = 0; e_oe = 0;
   endtask

   task automatic model_update();
      int run, d;
      logic done, cap;
      logic [4:0] dh;
      if (!rst) begin
         model_reset();
         return;
      end
      run = (m_s == m_p) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
      case (m_s[10:7])
         4'b1110: d = 0;
         4'b1101: d = 1;
         4'b1011: d = 2;
         4'b0111: d = 3;
         default: d = -1;
      endcase
      cap  = (d >= 0) && (run == SETTLE);
      done = (m_seen == 4'hF);
      e_fv = done;
      e_to = (m_to == (1 << TW) - 1) && !done;
      e_oe = 0;
      if (done) begin
         e_seg = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
         for (int k = 0; k < 4; k++) begin
            dh = ref_dec(m_slot[k]);
            e_ok[k] = dh[4];
            e_hex[4*k +: 4] = dh[3:0];
         end
      end
      m_to = done ? 0 : (m_to + 1) % (1 << TW);
      if (done || e_to) begin
         m_seen = '0;
         m_exp = 0;
      end
      if (cap) begin
`ifdef SCAN_ORDER_CHECK_EN
         if (d != m_exp) begin
            e_oe = 1;
            m_seen = '0;
            m_exp = (d == 0) ? 1 : 0;
            if (d == 0) m_seen[0] = 1'b1;
         end else begin
            m_seen[d] = 1'b1;
            m_exp = (m_exp + 1) % 4;
         end
`else
         m_seen[d] = 1'b1;
`endif
         m_slot[d] = m_s[6:0];
      end
      m_run = run;
      m_p = m_s;
      m_s = m_m;
      m_m = {an_in, seg_in};
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      chk("cycle", {frame_seg, frame_hex, hex_ok, frame_valid, err_timeout, order_err},
                   {e_seg, e_hex, e_ok, e_fv, e_to, e_oe});
      if (frame_valid) fv_cnt++;
      if (err_timeout) to_cnt++;
      if (order_err) oe_cnt++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      an_in = 4'hF;
      seg_in = 7'h7F;
      rst = 1'b0;
      model_reset();
      #1;
      chk("reset_state", {frame_seg, frame_hex, hex_ok, frame_valid, err_timeout, order_err},
                         {28'hFFFFFFF, 16'h0, 4'h0, 3'b000});
      repeat (2) step();
      rst = 1'b1;
      fv_cnt = 0; to_cnt = 0; oe_cnt = 0;
   endtask

   task automatic drive_digit(input int i, input logic [6:0] s, input int hold);
      logic [3:0] one;
      one = 4'b0001;
      an_in = ~(one << i);
      seg_in = s;
      repeat (hold) step();
   endtask

   task automatic scan(input logic [27:0] segs, input int hold, input int n);
      for (int i = 0; i < n; i++) drive_digit(i, segs[7*i +: 7], hold);
      an_in = 4'hF;
      seg_in = 7'h7F;
   endtask

   vec_t tbl [7];

   initial begin
      glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      tbl[0] = '{{7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}, 16'h3210, 4'hF};
      tbl[1] = '{{7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001}, 16'h7654, 4'hF};
      tbl[2] = '{{7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000}, 16'hBA98, 4'hF};
      tbl[3] = '{{7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110}, 16'hFEDC, 4'hF};
      tbl[4] = '{{7'b1000111, 7'b0100100, 7'b1111001, 7'b1000000}, 16'h0210, 4'b0111};
      tbl[5] = '{{7'h7F, 7'h7F, 7'h7F, 7'h7F}, 16'h0000, 4'h0};
      tbl[6] = '{{7'b0000000, 7'b0000000, 7'b0000001, 7'b0000000}, 16'h8808, 4'b1101};
      n_vec = 0; n_bad = 0;
      rst = 1'b1;
      an_in = 4'hF;
      seg_in = 7'h7F;

      for (int v = 0; v < 7; v++) begin
         do_reset();
         scan(tbl[v].segs, 8, 4);
         repeat (4) step();
         chk("tbl_frames", 64'(fv_cnt), 64'd1);
         chk("tbl_seg", 64'(frame_seg), 64'(tbl[v].segs));
         chk("tbl_hex", 64'(frame_hex), 64'(tbl[v].hex));
         chk("tbl_ok", 64'(hex_ok), 64'(tbl[v].ok));
      end

      // glitching segments never stay stable long enough to capture
      do_reset();
      an_in = 4'b1110;
      for (int k = 0; k < 40; k++) begin
         seg_in = ((k / 2) % 2 == 1) ? 7'b1111001 : 7'b1000000;
         step();
      end
      chk("glitch_frames", 64'(fv_cnt), 64'd0);
      chk("glitch_seg", 64'(frame_seg), 64'hFFFFFFF);

      do_reset();
      for (int n = 1; n <= 200; n++) begin
         step();
         chk("timeout_pulse", 64'(err_timeout), 64'(n % 64 == 0));
      end
      chk("timeout_count", 64'(to_cnt), 64'd3);

      do_reset();
      scan(tbl[0].segs, 8, 2);
      do_reset();
      scan(tbl[1].segs, 8, 4);
      repeat (4) step();
      chk("rst_mid_frames", 64'(fv_cnt), 64'd1);
      chk("rst_mid_hex", 64'(frame_hex), 64'h7654);

`ifdef SCAN_ORDER_CHECK_EN
      begin
         int ord [4];
         ord = '{0, 2, 1, 3};
         do_reset();
         for (int i = 0; i < 4; i++) drive_digit(ord[i], tbl[0].segs[7*ord[i] +: 7], 7);
         chk("order_err_count", 64'(oe_cnt), 64'd3);
         chk("order_no_frame", 64'(fv_cnt), 64'd0);
         scan(tbl[0].segs, 7, 4);
         repeat (3) step();
         chk("order_frames", 64'(fv_cnt), 64'd1);
         chk("order_hex", 64'(frame_hex), 64'h3210);
      end
`endif

      do_reset();
      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 9) < 7) begin
            logic [3:0] one;
            one = 4'b0001;
            an_in = ~(one << $urandom_range(0, 3));
         end else an_in = 4'($urandom);
         seg_in = ($urandom_range(0, 4) < 4) ? glyph[$urandom_range(0, 15)] : 7'($urandom);
         repeat ($urandom_range(1, 12)) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the multiplexed 7-segment driver.
- Samples the time-multiplexed `disp`/`anode` bus, waits for each digit slot to settle, and captures the four segment patterns.
- Decodes each pattern back to a hex nibble and publishes a complete frame with a one-cycle valid strobe.
- Used on-board for display self-check and in benches as a display monitor.

Parameters:
- SETTLE, 4: consecutive identical synchronized samples required before a digit is captured (legal range 1..255).
- TIMEOUT_W, 21: width of the frame-timeout counter; timeout fires after 2^TIMEOUT_W cycles without a completed frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- seg_in  in  7  segment lines, active-low; bit0 = a … bit6 = g.
- an_in  in  4  anode lines, active-low; bit i selects digit i.
- frame_seg  out  28  captured raw patterns; digit i is in [7i+6:7i].
- frame_hex  out  16  decoded nibbles; digit i is in [4i+3:4i].
- hex_ok  out  4  bit i = 1 if digit i's pattern is a legal hex glyph.
- frame_valid  out  1  one-cycle pulse when frame_* and hex_ok are updated.
- err_timeout  out  1  one-cycle pulse on frame timeout.
- order_err  out  1  one-cycle pulse on scan-order violation (optional feature; 0 when the feature is compiled out).

Behaviour:
- Reset state, all outputs:
  - frame_seg = all 1s.
  - frame_hex = 0.
  - hex_ok = 0.
  - All pulse outputs = 0.
  - Internal slots = all 1s; seen mask = 0; counters = 0; FSM in IDLE.
- Input path:
  - seg_in and an_in pass through a 2-FF synchronizer; all logic below uses the synchronized values.
  - Synchronized sample s = {an, seg}, with p = s from the previous cycle.
- FSM states: IDLE, SETTLING, HELD.
  - IDLE: if an has exactly one 0 bit, go to SETTLING with stable count = 1. Otherwise stay in IDLE (covers 4'b1111 and multiple low bits).
  - SETTLING:
    - If s != p, or an is not one-hot-low: stable count = 1, stay in SETTLING if an is one-hot-low, else go to IDLE.
    - Otherwise increment. When the count reaches SETTLE, capture seg into slot[i], set seen[i], and go to HELD.
  - HELD: no further capture while s == p. On any change of s, re-enter SETTLING (or IDLE if an is invalid). Each anode activation therefore produces exactly one capture.
- Capture rules:
  - A repeated digit before frame completion overwrites its slot; the latest capture wins.
- Frame completion:
  - In the cycle after seen becomes 4'b1111: frame_seg ← slots, frame_hex/hex_ok ← decode(slots), frame_valid = 1, seen ← 0.
- Latency: input change → capture = 2 + SETTLE cycles; capture of the 4th digit → frame_valid = 1 cycle.
- Decode table (active-low, a = bit0; matches seg7):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
  - Any other pattern: nibble = 0, hex_ok bit = 0.
- Timeout:
  - The counter increments every cycle and clears on frame_valid.
  - On wrap to 0 without a frame: err_timeout pulses, seen clears, slots are kept.
  - If frame completion and wrap occur in the same cycle, completion wins: no err_timeout.
- Reset asserted mid-frame: immediate return to the reset state; any partial frame is discarded.
- Outputs are registered; frame_* hold their values between frames.

Optional Feature:
- Macro: SCAN_ORDER_CHECK_EN.
- Defined:
  - Captures must occur in digit order 0,1,2,3.
  - A capture of any digit other than the expected one pulses order_err, clears seen, and restarts expectation at digit 0.
  - If the offending digit is 0, it is accepted as the new first capture.
- Undefined: any capture order is accepted; order_err is tied to 0.

Test Plan:
- Clean scan: drive digits 0..3 with patterns 1000000 / 1111001 / 0100100 / 0110000, each for 8 cycles, SETTLE = 4.
  - Expect one frame_valid, frame_hex = 16'h3210, hex_ok = 4'hF.
- Glitch rejection: toggle seg_in every 2 cycles on digit 0.
  - Expect no capture and no frame_valid; frame_seg stays all 1s.
- Non-hex glyph: digit 3 = 1000111 (L), others legal.
  - Expect hex_ok = 4'b0111 and frame_hex[15:12] = 0.
- Blanking and timeout: hold an_in = 4'b1111 with TIMEOUT_W = 6.
  - Expect err_timeout pulses at cycle 64, and every 64 cycles thereafter.
- Async reset mid-frame: assert rst low after 2 digits are captured, then release and run a full scan.
  - Expect exactly one frame_valid, with only post-reset data.
- With SCAN_ORDER_CHECK_EN: scan order 0,2,1,3.
  - Expect order_err on the digit-2 capture and no frame_valid until a correct 0-1-2-3 sequence completes.
